// File: rtl/blood_fx_pkg.sv
// +----------------------------------------------------------------------+
// | blood_fx_pkg : shared types and constants for the blood FX block     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package blood_fx_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } slot_state_t;

  localparam int SPR_DIM = 64;
  localparam int SPR_AW  = 6;
  localparam int COLOR_W = 12;
  localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;

  // Halve each 4-bit colour channel.
  function automatic logic [COLOR_W-1:0] dim_color(input logic [COLOR_W-1:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/blood_fx_slot.sv
// +----------------------------------------------------------------------+
// | blood_fx_slot : one fighter's effect timer, anchor and window test   |
// | Rev 1.0   (fade flag present only with BLOOD_FADE_EN)                |
// +----------------------------------------------------------------------+
`default_nettype none

module blood_fx_slot
  import blood_fx_pkg::*;
#(
  parameter int PIX_W       = 10,
  parameter int DUR_FRAMES  = 30,
  parameter int FADE_FRAMES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_tick,
  input  logic              hit,
  input  logic [PIX_W-1:0]  hit_x,
  input  logic [PIX_W-1:0]  hit_y,
  input  logic              video_on,
  input  logic [PIX_W-1:0]  pixel_x,
  input  logic [PIX_W-1:0]  pixel_y,
  output logic              active,
  output logic              in_win,
  output logic [SPR_AW-1:0] off_x,
  output logic [SPR_AW-1:0] off_y
`ifdef BLOOD_FADE_EN
  ,
  output logic              fading
`endif
);

  localparam logic [7:0] DUR_CNT = 8'(DUR_FRAMES);

  slot_state_t      state;
  logic [7:0]       cnt;
  logic [PIX_W-1:0] anchor_x;
  logic [PIX_W-1:0] anchor_y;
  logic [PIX_W:0]   dx;
  logic [PIX_W:0]   dy;

  // A retrigger takes priority over the expiring tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      anchor_x <= '0;
      anchor_y <= '0;
    end else if (hit) begin
      state    <= ACTIVE;
      cnt      <= DUR_CNT;
      anchor_x <= hit_x;
      anchor_y <= hit_y;
    end else if (state == ACTIVE && frame_tick) begin
      cnt <= cnt - 8'd1;
      if (cnt == 8'd1) state <= IDLE;
    end
  end

  // One extra bit keeps a pixel left of/above the anchor from wrapping into the window.
  assign dx     = {1'b0, pixel_x} - {1'b0, anchor_x};
  assign dy     = {1'b0, pixel_y} - {1'b0, anchor_y};
  assign active = (state == ACTIVE);
  assign in_win = active && video_on
                  && !dx[PIX_W] && (dx[PIX_W-1:SPR_AW] == '0)
                  && !dy[PIX_W] && (dy[PIX_W-1:SPR_AW] == '0);
  assign off_x  = dx[SPR_AW-1:0];
  assign off_y  = dy[SPR_AW-1:0];

`ifdef BLOOD_FADE_EN
  assign fading = (cnt <= 8'(FADE_FRAMES));
`endif

endmodule

`default_nettype wire

// File: rtl/blood_fx_controller.sv
// +----------------------------------------------------------------------+
// | blood_fx_controller : two-slot blood splatter scheduler, arbiter and |
// | 3-stage ROM pixel pipeline. Optional dimming tail: BLOOD_FADE_EN.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module blood_fx_controller
  import blood_fx_pkg::*;
#(
  parameter int PIX_W       = 10,
  parameter int DUR_FRAMES  = 30,
  parameter int FADE_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               video_on,
  input  logic [PIX_W-1:0]   pixel_x,
  input  logic [PIX_W-1:0]   pixel_y,
  input  logic               hit_p1,
  input  logic               hit_p2,
  input  logic [PIX_W-1:0]   hit_x_p1,
  input  logic [PIX_W-1:0]   hit_y_p1,
  input  logic [PIX_W-1:0]   hit_x_p2,
  input  logic [PIX_W-1:0]   hit_y_p2,
  output logic [SPR_AW-1:0]  rom_row,
  output logic [SPR_AW-1:0]  rom_col,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               blood_on,
  output logic [COLOR_W-1:0] blood_rgb,
  output logic [1:0]         fx_active
);

  generate
    if (DUR_FRAMES < 1 || DUR_FRAMES > 255 || FADE_FRAMES >= DUR_FRAMES) begin : g_param_check
      $error("blood_fx_controller: DUR_FRAMES must be 1..255 and exceed FADE_FRAMES");
    end
  endgenerate

  logic [1:0]        hit_vec;
  logic [PIX_W-1:0]  hx [2];
  logic [PIX_W-1:0]  hy [2];
  logic [1:0]        act;
  logic [1:0]        win;
  logic [1:0]        fade_vec;
  logic [SPR_AW-1:0] off_x [2];
  logic [SPR_AW-1:0] off_y [2];
  logic              last_hit;
  logic              sel;
  logic              tag_v, tag_v_d;
  logic              tag_f, tag_f_d;
  logic              opaque;
  logic [COLOR_W-1:0] color;

  assign hit_vec = {hit_p2, hit_p1};
  assign hx[0]   = hit_x_p1;
  assign hy[0]   = hit_y_p1;
  assign hx[1]   = hit_x_p2;
  assign hy[1]   = hit_y_p2;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_slot
      blood_fx_slot #(
        .PIX_W       (PIX_W),
        .DUR_FRAMES  (DUR_FRAMES),
        .FADE_FRAMES (FADE_FRAMES)
      ) u_slot (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .hit        (hit_vec[i]),
        .hit_x      (hx[i]),
        .hit_y      (hy[i]),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .active     (act[i]),
        .in_win     (win[i]),
        .off_x      (off_x[i]),
        .off_y      (off_y[i])
`ifdef BLOOD_FADE_EN
        ,
        .fading     (fade_vec[i])
`endif
      );
    end
  endgenerate

`ifndef BLOOD_FADE_EN
  assign fade_vec = 2'b00;
`endif

  // On overlap the most recently hit fighter is drawn on top.
  assign sel       = (win[0] && win[1]) ? last_hit : win[1];
  assign fx_active = act;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_hit <= 1'b0;
      rom_row  <= '0;
      rom_col  <= '0;
      tag_v    <= 1'b0;
      tag_f    <= 1'b0;
      tag_v_d  <= 1'b0;
      tag_f_d  <= 1'b0;
    end else begin
      if (hit_p2)      last_hit <= 1'b1;
      else if (hit_p1) last_hit <= 1'b0;
      tag_v <= |win;
      tag_f <= fade_vec[sel] && (|win);
      if (|win) begin
        rom_row <= off_y[sel];
        rom_col <= off_x[sel];
      end
      tag_v_d <= tag_v;
      tag_f_d <= tag_f;
    end
  end

  // Transparency is judged on the raw ROM word, so a dimmed 000 stays opaque.
  assign opaque = tag_v_d && (rom_data != TRANSPARENT);
  assign color  = tag_f_d ? dim_color(rom_data) : rom_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blood_on  <= 1'b0;
      blood_rgb <= '0;
    end else begin
      blood_on  <= opaque;
      blood_rgb <= opaque ? color : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_blood_fx_controller.sv
// +----------------------------------------------------------------------+
// | tb_blood_fx_controller : scoreboard bench with a frame-level model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_blood_fx_controller;

  localparam int PIX_W = 10;
  localparam int DUR   = 30;
  localparam int FADE  = 8;
  localparam int PMASK = (1 << PIX_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             frame_tick = 1'b0;
  logic             video_on = 1'b0;
  logic [PIX_W-1:0] pixel_x = '0, pixel_y = '0;
  logic             hit_p1 = 1'b0, hit_p2 = 1'b0;
  logic [PIX_W-1:0] hit_x_p1 = '0, hit_y_p1 = '0, hit_x_p2 = '0, hit_y_p2 = '0;
  logic [5:0]       rom_row, rom_col;
  logic [11:0]      rom_data = '0;
  logic             blood_on;
  logic [11:0]      blood_rgb;
  logic [1:0]       fx_active;

  always #5 clk = ~clk;

  blood_fx_controller #(.PIX_W(PIX_W), .DUR_FRAMES(DUR), .FADE_FRAMES(FADE)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .hit_p1(hit_p1), .hit_p2(hit_p2),
    .hit_x_p1(hit_x_p1), .hit_y_p1(hit_y_p1), .hit_x_p2(hit_x_p2), .hit_y_p2(hit_y_p2),
    .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
    .blood_on(blood_on), .blood_rgb(blood_rgb), .fx_active(fx_active)
  );

  // Sprite ROM content: a few transparent texels, the rest an address-derived colour.
  function automatic logic [11:0] rom_f(input logic [5:0] r, input logic [5:0] c);
    if (((int'(r) + int'(c)) % 7) == 0) return 12'h000;
    return {r[3:0], c[3:0], 4'h8};
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_row, rom_col);

  typedef struct {
    logic [1:0]  fx;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        on;
    logic [11:0] rgb;
  } exp_t;

  exp_t q_fast[$];
  exp_t pend[$];
  exp_t mon_e, mon_b;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  // Reference model: effect lifetimes counted in frames, anchors, most recent hit.
  bit m_act[2];
  int m_cnt[2];
  int m_ax[2], m_ay[2];
  int m_last, m_row, m_col;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_cnt[i] = 0; m_ax[i] = 0; m_ay[i] = 0;
    end
    m_last = 0; m_row = 0; m_col = 0;
  endtask

  task automatic cycle(input bit h1, input bit h2, input int x1, input int y1,
                       input int x2, input int y2, input bit tick, input bit von,
                       input int px, input int py);
    exp_t        e;
    int          dx[2], dy[2];
    bit          w[2];
    bit          h[2];
    int          xs[2], ys[2];
    int          s;
    logic [11:0] d;
    @(negedge clk);
    hit_p1 = h1; hit_p2 = h2;
    hit_x_p1 = x1[PIX_W-1:0]; hit_y_p1 = y1[PIX_W-1:0];
    hit_x_p2 = x2[PIX_W-1:0]; hit_y_p2 = y2[PIX_W-1:0];
    frame_tick = tick; video_on = von;
    pixel_x = px[PIX_W-1:0]; pixel_y = py[PIX_W-1:0];
    for (int i = 0; i < 2; i++) begin
      dx[i] = px - m_ax[i];
      dy[i] = py - m_ay[i];
      w[i]  = m_act[i] && von && dx[i] >= 0 && dx[i] < 64 && dy[i] >= 0 && dy[i] < 64;
    end
    e.on = 1'b0; e.rgb = '0;
    if (w[0] || w[1]) begin
      s = (w[0] && w[1]) ? m_last : (w[1] ? 1 : 0);
      m_row = dy[s]; m_col = dx[s];
      d = rom_f(6'(m_row), 6'(m_col));
      e.on  = (d != 12'h000);
      e.rgb = d;
`ifdef BLOOD_FADE_EN
      if (m_cnt[s] <= FADE)
        for (int k = 0; k < 3; k++) e.rgb[4*k +: 4] = d[4*k +: 4] >> 1;
`endif
    end
    e.row = 6'(m_row); e.col = 6'(m_col);
    h[0] = h1; h[1] = h2; xs[0] = x1; xs[1] = x2; ys[0] = y1; ys[1] = y2;
    for (int i = 0; i < 2; i++) begin
      if (h[i]) begin
        m_act[i] = 1'b1; m_cnt[i] = DUR; m_ax[i] = xs[i]; m_ay[i] = ys[i];
      end else if (m_act[i] && tick) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) m_act[i] = 1'b0;
      end
    end
    if (h2) m_last = 1; else if (h1) m_last = 0;
    e.fx = {m_act[1], m_act[0]};
    q_fast.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int x, input int y);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, x, y);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_blood_on"}, 32'(blood_on), 32'd0);
    chk({tag, "_fx_active"}, 32'(fx_active), 32'd0);
    chk({tag, "_rom_row"}, 32'(rom_row), 32'd0);
    chk({tag, "_rom_col"}, 32'(rom_col), 32'd0);
  endtask

  // Monitor: address/state one edge after a pixel, colour two edges after that.
  always @(posedge clk) begin
    #1;
    if (mon_en && q_fast.size() > 0) begin
      mon_e = q_fast.pop_front();
      chk("fx_active", 32'(fx_active), 32'(mon_e.fx));
      chk("rom_row", 32'(rom_row), 32'(mon_e.row));
      chk("rom_col", 32'(rom_col), 32'(mon_e.col));
      pend.push_back(mon_e);
      if (pend.size() == 3) begin
        mon_b = pend.pop_front();
        chk("blood_on", 32'(blood_on), 32'(mon_b.on));
        chk("blood_rgb", 32'(blood_rgb), 32'(mon_b.rgb));
      end
    end
  end

  initial begin
    int s, x1, y1, x2, y2, px, py;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Single hit, inside and just outside the 64-wide window, transparent texel, video off.
    cycle(1, 0, 100, 200, 0, 0, 0, 0, 0, 0);
    pix(110, 205); pix(164, 205); pix(163, 263); pix(99, 205); pix(104, 203);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 110, 205);
    idle(3);

    // Lifetime: expiry after the 30th tick, then a retrigger on the 30th tick.
    for (int i = 0; i < DUR; i++) cycle(0, 0, 0, 0, 0, 0, 1, 1, 100 + i, 200 + i);
    idle(2);
    cycle(1, 0, 100, 200, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DUR - 1; i++) cycle(0, 0, 0, 0, 0, 0, 1, 1, 110, 205);
    cycle(1, 0, 100, 200, 0, 0, 1, 1, 110, 205);
    for (int i = 0; i < DUR; i++) cycle(0, 0, 0, 0, 0, 0, 1, 1, 101 + i, 201);
    idle(2);

    // Overlap arbitration: later hit wins, simultaneous hits favour P2.
    cycle(0, 1, 0, 0, 100, 200, 0, 0, 0, 0);
    idle(1);
    cycle(1, 0, 120, 200, 0, 0, 0, 0, 0, 0);
    pix(130, 210); pix(125, 201);
    cycle(1, 1, 100, 200, 110, 200, 0, 0, 0, 0);
    pix(115, 210); pix(105, 210);

    // Screen-edge clipping: no wrap below the anchor.
    cycle(1, 0, 1000, 1000, 0, 0, 0, 0, 0, 0);
    pix(1023, 1020); pix(5, 5); pix(999, 1001);
    idle(2);

    // Reset in the middle of live effects.
    cycle(1, 1, 300, 300, 310, 305, 0, 0, 0, 0);
    pix(320, 320); pix(330, 310);
    @(posedge clk); #2;
    mon_en = 1'b0;
    q_fast.delete(); pend.delete();
    @(negedge clk) reset_n = 1'b0;
    #1 chk_zero("rst_low");
    repeat (2) begin @(posedge clk); #1 chk_zero("rst_low"); end
    @(negedge clk);
    hit_p1 = 1'b0; hit_p2 = 1'b0; frame_tick = 1'b0; video_on = 1'b0;
    reset_n = 1'b1;
    model_reset();
    repeat (3) begin @(posedge clk); #1 chk_zero("rst_rel"); end
    mon_en = 1'b1;

    // Randomised traffic around the live anchors.
    for (int n = 0; n < 4000; n++) begin
      x1 = $urandom_range(0, PMASK); y1 = $urandom_range(0, PMASK);
      if ($urandom_range(0, 2) == 0) begin
        x2 = (x1 + $urandom_range(0, 40)) & PMASK; y2 = (y1 + $urandom_range(0, 40)) & PMASK;
      end else begin
        x2 = $urandom_range(0, PMASK); y2 = $urandom_range(0, PMASK);
      end
      s  = $urandom_range(0, 1);
      px = (m_ax[s] + $urandom_range(0, 80) - 8) & PMASK;
      py = (m_ay[s] + $urandom_range(0, 80) - 8) & PMASK;
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0, x1, y1, x2, y2,
            $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0, px, py);
    end
    idle(5);
    @(posedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
